// File: rtl/uart_mem_dump_fill.sv
// Monitor memory engine: single-word writes, ranged dumps and ranged pattern fills
// against a LANES-wide data RAM; one fetched line feeds every packet it contains.
module uart_mem_dump_fill #(
    parameter int LANES     = 4,
    parameter int SND_WORDS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             uart_data,
    input  logic                    wadr_set,
    input  logic                    wdata_en,
    input  logic                    rd_start_set,
    input  logic                    rd_end_set,
    input  logic                    rd_stop,
    input  logic                    fill_start_set,
    input  logic                    fill_pat_set,
    input  logic                    fill_end_set,
    input  logic                    fill_incr,
    output logic [31:0]             d_ram_radr,
    output logic                    d_ram_rreq,
    input  logic [32*LANES-1:0]     d_ram_rdata,
    input  logic                    d_ram_rvalid,
    output logic [31:0]             d_ram_wadr,
    output logic [32*LANES-1:0]     d_ram_wdata,
    output logic [4*LANES-1:0]      d_ram_wmask,
    output logic                    d_ram_wreq,
    input  logic                    d_ram_wresp,
    output logic                    snd_start,
    output logic [32*SND_WORDS-1:0] snd_data,
    input  logic                    snd_done,
    output logic                    busy,
    output logic                    err
);
    localparam int LW = $clog2(LANES);
    localparam int DW = 32 * LANES;
    localparam int MW = 4 * LANES;
    localparam int PW = 32 * SND_WORDS;
    localparam logic [30:0] SND_ALIGN  = ~(31'(SND_WORDS) - 31'd1);
    localparam logic [31:0] LINE_ALIGN = ~(32'(4 * LANES) - 32'd1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RREQ  = 4'd1,
        S_RWAIT = 4'd2,
        S_SEND  = 4'd3,
        S_SWAIT = 4'd4,
        S_FCHK  = 4'd5,
        S_FWR   = 4'd6,
        S_FWAIT = 4'd7
    } state_t;

    function automatic logic [31:0] line_addr(input logic [29:0] word_adr);
        return {word_adr, 2'b00} & LINE_ALIGN;
    endfunction

    function automatic logic [MW-1:0] lane_mask(input logic [LW-1:0] lane);
        logic [MW-1:0] m;
        m = {MW{1'b1}};
        m[4*int'(lane) +: 4] = 4'b0000;
        return m;
    endfunction

    state_t         state_r;
    logic [29:0]    wadr_r;
    logic [29:0]    rd_start_r;
    logic [29:0]    fill_start_r;
    logic [31:0]    pat_r;
    logic [31:0]    fpat_r;
    logic           incr_r;
    logic [30:0]    cur_r;
    logic [30:0]    end_r;
    logic [DW-1:0]  line_r;
    logic [31:0]    radr_r;
    logic           rreq_r;
    logic [31:0]    fwadr_r;
    logic [DW-1:0]  fwdata_r;
    logic [MW-1:0]  fwmask_r;
    logic           fwreq_r;
    logic           snd_start_r;
    logic [PW-1:0]  snd_data_r;
    logic           err_r;

    logic           idle_s;
    logic           start_dump_s;
    logic           start_fill_s;
    logic           single_wr_s;
    logic           strobe_any_s;
    logic           err_set_s;
    logic [30:0]    dump_base_s;
    logic [30:0]    snd_nxt_s;
    logic           full_line_s;
    logic           unused_s;

    assign idle_s       = (state_r == S_IDLE);
    assign start_dump_s = idle_s & rd_end_set;
    assign start_fill_s = idle_s & fill_end_set & ~rd_end_set;
    assign single_wr_s  = idle_s & wdata_en & ~rd_end_set & ~fill_end_set;
    assign strobe_any_s = wadr_set | wdata_en | rd_start_set | rd_end_set
                        | fill_start_set | fill_pat_set | fill_end_set;
    // Same-cycle starters lose to rd_end_set, then fill_end_set.
    assign err_set_s    = (~idle_s & strobe_any_s)
                        | (idle_s & rd_end_set & (fill_end_set | wdata_en))
                        | (idle_s & fill_end_set & wdata_en);
    assign dump_base_s  = {1'b0, rd_start_r} & SND_ALIGN;
    assign snd_nxt_s    = cur_r + 31'(SND_WORDS);
    assign full_line_s  = (cur_r[LW-1:0] == '0) && ((cur_r + 31'(LANES - 1)) <= end_r);
    assign unused_s     = ^uart_data[1:0];

    // Command operand registers and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wadr_r       <= 30'd0;
            rd_start_r   <= 30'd0;
            fill_start_r <= 30'd0;
            pat_r        <= 32'd0;
            err_r        <= 1'b0;
        end else begin
            if (err_set_s) begin
                err_r <= 1'b1;
            end
            if (idle_s) begin
                if (wadr_set) begin
                    wadr_r <= uart_data[31:2];
                end else if (single_wr_s) begin
                    wadr_r <= wadr_r + 30'd1;
                end
                if (rd_start_set) begin
                    rd_start_r <= uart_data[31:2];
                end
                if (fill_start_set) begin
                    fill_start_r <= uart_data[31:2];
                end
                if (fill_pat_set) begin
                    pat_r <= uart_data;
                end
            end
        end
    end

    // Dump/fill sequencer with registered request and packet outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cur_r       <= 31'd0;
            end_r       <= 31'd0;
            fpat_r      <= 32'd0;
            incr_r      <= 1'b0;
            line_r      <= '0;
            radr_r      <= 32'd0;
            rreq_r      <= 1'b0;
            fwadr_r     <= 32'd0;
            fwdata_r    <= '0;
            fwmask_r    <= {MW{1'b1}};
            fwreq_r     <= 1'b0;
            snd_start_r <= 1'b0;
            snd_data_r  <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_dump_s) begin
                        end_r   <= {1'b0, uart_data[31:2]};
                        cur_r   <= dump_base_s;
                        radr_r  <= line_addr(dump_base_s[29:0]);
                        rreq_r  <= 1'b1;
                        state_r <= S_RREQ;
                    end else if (start_fill_s) begin
                        end_r   <= {1'b0, uart_data[31:2]};
                        cur_r   <= {1'b0, fill_start_r};
                        fpat_r  <= pat_r;
                        incr_r  <= fill_incr;
                        state_r <= S_FCHK;
                    end
                end
                S_RREQ: begin
                    rreq_r  <= 1'b0;
                    state_r <= rd_stop ? S_IDLE : S_RWAIT;
                end
                S_RWAIT: begin
                    if (rd_stop) begin
                        state_r <= S_IDLE;
                    end else if (d_ram_rvalid) begin
                        line_r  <= d_ram_rdata;
                        state_r <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (rd_stop) begin
                        state_r <= S_IDLE;
                    end else begin
                        snd_data_r  <= line_r[32*int'(cur_r[LW-1:0]) +: PW];
                        snd_start_r <= 1'b1;
                        state_r     <= S_SWAIT;
                    end
                end
                S_SWAIT: begin
                    snd_start_r <= 1'b0;
                    if (rd_stop) begin
                        state_r <= S_IDLE;
                    end else if (snd_done) begin
                        cur_r <= snd_nxt_s;
                        // Carry bit set means the address space wrapped.
                        if (snd_nxt_s[30] || (snd_nxt_s > end_r)) begin
                            state_r <= S_IDLE;
                        end else if (snd_nxt_s[LW-1:0] == '0) begin
                            radr_r  <= line_addr(snd_nxt_s[29:0]);
                            rreq_r  <= 1'b1;
                            state_r <= S_RREQ;
                        end else begin
                            state_r <= S_SEND;
                        end
                    end
                end
                S_FCHK: begin
                    fwadr_r <= line_addr(cur_r[29:0]);
                    fwreq_r <= 1'b1;
                    state_r <= S_FWR;
                    if (full_line_s) begin
                        for (int i = 0; i < LANES; i++) begin
                            fwdata_r[32*i +: 32] <= incr_r ? (fpat_r + 32'(i)) : fpat_r;
                        end
                        fwmask_r <= {MW{1'b0}};
                        cur_r    <= cur_r + 31'(LANES);
                        fpat_r   <= fpat_r + (incr_r ? 32'(LANES) : 32'd0);
                    end else begin
                        fwdata_r <= {LANES{fpat_r}};
                        fwmask_r <= lane_mask(cur_r[LW-1:0]);
                        cur_r    <= cur_r + 31'd1;
                        fpat_r   <= fpat_r + (incr_r ? 32'd1 : 32'd0);
                    end
                end
                S_FWR: begin
                    fwreq_r  <= 1'b0;
                    fwmask_r <= {MW{1'b1}};
                    state_r  <= S_FWAIT;
                end
                S_FWAIT: begin
                    if (d_ram_wresp) begin
                        if (cur_r[30] || (cur_r > end_r)) begin
                            state_r <= S_IDLE;
                        end else begin
                            state_r <= S_FCHK;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Write port: the single-word write bypasses the fill write registers.
    always_comb begin
        d_ram_wreq = fwreq_r | single_wr_s;
        if (single_wr_s) begin
            d_ram_wadr  = line_addr(wadr_r);
            d_ram_wdata = {LANES{uart_data}};
            d_ram_wmask = lane_mask(wadr_r[LW-1:0]);
        end else begin
            d_ram_wadr  = fwadr_r;
            d_ram_wdata = fwdata_r;
            d_ram_wmask = fwmask_r;
        end
    end

    assign d_ram_radr = radr_r;
    assign d_ram_rreq = rreq_r;
    assign snd_start  = snd_start_r;
    assign snd_data   = snd_data_r;
    assign busy       = ~idle_s;
    assign err        = err_r;

endmodule
